// File: rtl/prog_loader_pkg.sv
// Shared encodings for the program loader: FSM states, target select,
// error bit positions and pointer step sizes.
package prog_loader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_RUN   = 2'd3;

    localparam logic TGT_INST = 1'b0;
    localparam logic TGT_DATA = 1'b1;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_WRAP     = 1;

    localparam int ISTEP = 1;
    localparam int DSTEP = 4;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready command stream feeding the loader: one beat per handshake.
interface prog_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_sel;
    logic              cmd_auto;
    logic              cmd_last;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_sel, cmd_auto, cmd_last, cmd_addr, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_auto, cmd_last, cmd_addr, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/loader_ptr.sv
// Auto-increment address pointer: advances to (base + STEP), where base is
// either the current value or an explicitly loaded address; wraps to 0 on carry.
module loader_ptr #(
    parameter int W    = 10,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         wrap
);
    logic [W-1:0] base;
    logic [W:0]   sum;

    assign base = load ? load_value : value;
    assign sum  = {1'b0, base} + (W+1)'(STEP);
    assign wrap = sum[W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         value <= '0;
        else if (clear)   value <= '0;
        else if (advance) value <= wrap ? '0 : sum[W-1:0];
    end
endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams command beats into instruction/data memory, tracks
// checksum/errors/halt sentinel, and holds the core until the last beat lands.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                IADDR_W   = 10,
    parameter int                DADDR_W   = 10,
    parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    prog_loader_if.slave       cmd,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               cpu_run,
    output logic               busy,
    output logic               done,
    output logic               halt_seen,
    output logic [1:0]         err,
    output logic [IADDR_W:0]   inst_count,
    output logic [DATA_W-1:0]  checksum
);
    state_t             state;
    logic               accept;
    logic               session_clr;
    logic               is_inst;
    logic               is_data;
    logic               misalign;
    logic [IADDR_W-1:0] iptr;
    logic [DADDR_W-1:0] dptr;
    logic [IADDR_W-1:0] iaddr;
    logic [DADDR_W-1:0] daddr;
    logic               iwrap;
    logic               dwrap;

    assign cmd.cmd_ready = (state == ST_LOAD);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign session_clr   = start & ((state == ST_IDLE) | (state == ST_RUN));
    assign is_inst       = accept & (cmd.cmd_sel == TGT_INST);
    assign is_data       = accept & (cmd.cmd_sel == TGT_DATA);
    assign busy          = (state == ST_LOAD) | (state == ST_DRAIN);
    assign cpu_run       = (state == ST_RUN);

    assign iaddr    = cmd.cmd_auto ? iptr : cmd.cmd_addr[IADDR_W-1:0];
    assign daddr    = cmd.cmd_auto ? dptr : cmd.cmd_addr[DADDR_W-1:0];
    assign misalign = (daddr[1:0] != 2'b00);

    loader_ptr #(.W(IADDR_W), .STEP(ISTEP)) u_iptr (
        .clk        (clk),
        .rst        (rst),
        .clear      (session_clr),
        .load       (~cmd.cmd_auto),
        .advance    (is_inst),
        .load_value (cmd.cmd_addr[IADDR_W-1:0]),
        .value      (iptr),
        .wrap       (iwrap)
    );

    loader_ptr #(.W(DADDR_W), .STEP(DSTEP)) u_dptr (
        .clk        (clk),
        .rst        (rst),
        .clear      (session_clr),
        .load       (~cmd.cmd_auto),
        .advance    (is_data),
        .load_value (cmd.cmd_addr[DADDR_W-1:0]),
        .value      (dptr),
        .wrap       (dwrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            done <= (state == ST_DRAIN);
            case (state)
                ST_IDLE:  if (start) state <= ST_LOAD;
                ST_LOAD:  if (accept && cmd.cmd_last) state <= ST_DRAIN;
                ST_DRAIN: state <= ST_RUN;
                ST_RUN:   if (start) state <= ST_LOAD;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Write ports are registered one cycle behind acceptance; reset drops
    // any write still pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            imem_we <= is_inst;
            dmem_we <= is_data & ~misalign;
            if (is_inst) begin
                imem_addr  <= iaddr;
                imem_wdata <= cmd.cmd_data;
            end
            if (is_data) begin
                dmem_addr  <= daddr;
                dmem_wdata <= cmd.cmd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum   <= '0;
            inst_count <= '0;
            err        <= '0;
            halt_seen  <= 1'b0;
        end else if (session_clr) begin
            checksum   <= '0;
            inst_count <= '0;
            err        <= '0;
            halt_seen  <= 1'b0;
        end else if (accept) begin
            checksum <= checksum + cmd.cmd_data;
            if (is_inst) begin
                if (inst_count != '1) inst_count <= inst_count + 1'b1;
                if (cmd.cmd_data == HALT_WORD) halt_seen <= 1'b1;
                if (iwrap) err[ERR_WRAP] <= 1'b1;
            end else begin
                if (misalign) err[ERR_MISALIGN] <= 1'b1;
                if (dwrap) err[ERR_WRAP] <= 1'b1;
            end
        end
    end
endmodule
